// File: rtl/fetch_ctrl_if.sv
// Bundle for the fetch controller: program-control inputs and the instruction address/status outputs.
// master drives the controls (sequencer/testbench); slave is the fetch controller itself.
interface fetch_ctrl_if #(
  parameter int A = 10
);
  logic         Start;
  logic         Halt;
  logic         Stall;
  logic         Jump;
  logic [A-1:0] Target;
  logic [A-1:0] ProgCtr;
  logic         Running;
  logic         Done;
  logic         Overflow;
  logic [15:0]  InstCount;

  modport master (
    output Start, Halt, Stall, Jump, Target,
    input  ProgCtr, Running, Done, Overflow, InstCount
  );

  modport slave (
    input  Start, Halt, Stall, Jump, Target,
    output ProgCtr, Running, Done, Overflow, InstCount
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/DONE sequencer producing a registered ROM address.
// Define FETCH_REL_BRANCH_EN for PC-relative branches; default build uses absolute targets.
module fetch_ctrl #(
  parameter int           A          = 10,
  parameter logic [A-1:0] START_ADDR = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [A-1:0] pc_reg, pc_next;
  logic [15:0]  count_reg, count_next;
  logic         ovf_reg, ovf_next;

  logic [A-1:0] jump_target;
  logic [15:0]  count_inc;

`ifdef FETCH_REL_BRANCH_EN
  // Target is A-bit two's complement; the sum wraps naturally without touching Overflow.
  assign jump_target = pc_reg + bus.Target;
`else
  assign jump_target = bus.Target;
`endif

  assign count_inc = (&count_reg) ? count_reg : count_reg + 16'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      pc_reg    <= START_ADDR;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (state_reg == IDLE) pc_next = START_ADDR;
        if (bus.Start) begin
          state_next = RUN;
          pc_next    = START_ADDR;
          count_next = '0;
          ovf_next   = 1'b0;
        end
      end
      RUN: begin
        // Priority: Halt, Stall, Jump, increment.
        if (bus.Halt) begin
          state_next = DONE;
        end else if (!bus.Stall) begin
          count_next = count_inc;
          if (bus.Jump) begin
            pc_next = jump_target;
          end else begin
            pc_next = pc_reg + A'(1);
            if (&pc_reg) ovf_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.Running   = (state_reg == RUN);
    bus.Done      = (state_reg == DONE);
    bus.ProgCtr   = pc_reg;
    bus.Overflow  = ovf_reg;
    bus.InstCount = count_reg;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl: a driver pushes reference-model expectations,
// a monitor pops and compares after every clock edge.
module tb_fetch_ctrl;
  localparam int A = 10;
  localparam int N = 1 << A;
  localparam int START = 0;
`ifdef FETCH_REL_BRANCH_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  fetch_ctrl_if #(.A(A)) bus ();

  fetch_ctrl #(.A(A), .START_ADDR(A'(START))) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int pc;
    bit run;
    bit done;
    bit ovf;
    int cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: running/done flags plus address, count and sticky wrap flag.
  bit m_run, m_done, m_ovf;
  int m_pc, m_cnt;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_ovf = 0; m_pc = START; m_cnt = 0;
  endtask

  task automatic model_update(bit s, bit h, bit st, bit j, int t);
    if (!m_run) begin
      if (s) begin
        m_run = 1; m_done = 0; m_pc = START; m_cnt = 0; m_ovf = 0;
      end
    end else if (h) begin
      m_run = 0; m_done = 1;
    end else if (!st) begin
      if (j) m_pc = REL ? (m_pc + t) % N : t % N;
      else begin
        if (m_pc == N - 1) m_ovf = 1;
        m_pc = (m_pc + 1) % N;
      end
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic step(bit s, bit h, bit st, bit j, int t);
    @(negedge Clk);
    bus.Start  = s;
    bus.Halt   = h;
    bus.Stall  = st;
    bus.Jump   = j;
    bus.Target = t[A-1:0];
    model_update(s, h, st, j, t);
    q.push_back('{m_pc, m_run, m_done, m_ovf, m_cnt});
  endtask

  // Jump so that the resulting address is addr, in either branch mode.
  task automatic jump_to(int addr);
    step(0, 0, 0, 1, REL ? (addr - m_pc + N) % N : addr);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_pc"},   int'(bus.ProgCtr), START);
    check({tag, "_run"},  int'(bus.Running), 0);
    check({tag, "_done"}, int'(bus.Done), 0);
    check({tag, "_ovf"},  int'(bus.Overflow), 0);
    check({tag, "_cnt"},  int'(bus.InstCount), 0);
  endtask

  // Assert Reset between edges and check outputs before the next edge arrives.
  task automatic async_reset_check();
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    bus.Start = 0; bus.Halt = 0; bus.Stall = 0; bus.Jump = 0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ProgCtr",   int'(bus.ProgCtr),   e.pc);
        check("Running",   int'(bus.Running),   int'(e.run));
        check("Done",      int'(bus.Done),      int'(e.done));
        check("Overflow",  int'(bus.Overflow),  int'(e.ovf));
        check("InstCount", int'(bus.InstCount), e.cnt);
        $display("t=%0t pc=%0d run=%0b done=%0b ovf=%0b cnt=%0d",
                 $time, bus.ProgCtr, bus.Running, bus.Done, bus.Overflow, bus.InstCount);
      end
    end
  end

  initial begin : driver
    int r;
    bus.Start = 0; bus.Halt = 0; bus.Stall = 0; bus.Jump = 0; bus.Target = '0;
    model_reset();
    #2;
    check_reset_values("por");
    @(negedge Clk);
    Reset = 1'b0;

    // Stays idle without Start, then a start and five free-running cycles.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 33);
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);

    // Stall beats Jump, then the jump lands.
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 40);
    jump_to(40);

    // Start ignored in RUN; Halt beats Jump; DONE holds everything.
    step(1, 0, 0, 0, 0);
    jump_to(12);
    step(0, 1, 0, 1, 55);
    step(0, 0, 1, 1, 77);
    step(0, 0, 0, 0, 0);

    // Negative offsets / absolute high targets, including a wrap through a branch.
    step(1, 0, 0, 0, 0);
    jump_to(100);
    step(0, 0, 0, 1, 'h3FC);
    jump_to(2);
    step(0, 0, 0, 1, 'h3FC);
    jump_to(N - 1);
    jump_to(0);

    // Sequential wrap sets Overflow; Halt holds; restart clears.
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (N) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Async reset while running.
    jump_to(300);
    async_reset_check();
    step(0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 999);
      if (r < 5) async_reset_check();
      else step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12,
                $urandom_range(0, N - 1));
    end

    @(posedge Clk);
    #2;
    check("queue_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
